// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle fetch/decode/control FSM for the 8-bit processor.
// Bank and data-memory strobes decode from the state register so they stay stable across the bank's falling-edge write.
module unidade_controle_multiciclo #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [1:0] read_register_1,
    output logic [1:0] read_register_2,
    input  logic [7:0] reg_data_1,
    input  logic [7:0] reg_data_2,
    output logic [1:0] write_register,
    output logic       write_enable,
    output logic [7:0] wb_data,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    output logic       dmem_we,
    input  logic [7:0] dmem_rdata,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_wb;
    logic       r_illegal;
    logic [3:0] w_op;
    logic       w_alu;
    assign w_op            = r_ir[7:4];
    assign w_alu           = (w_op >= 4'h1) && (w_op <= 4'h6);
    assign imem_addr       = r_pc;
    assign read_register_1 = r_ir[3:2];
    assign read_register_2 = r_ir[1:0];
    assign write_register  = r_ir[3:2];
    assign wb_data         = r_wb;
    assign alu_op          = w_alu ? w_op[2:0] - 3'd1 : 3'd0;
    assign dmem_addr       = reg_data_2;
    assign dmem_wdata      = reg_data_1;
    assign write_enable    = r_state == WB;
    assign dmem_we         = (r_state == EXEC) && (w_op == 4'h8);
    assign halted          = r_state == HALT;
    assign illegal         = r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_pc      <= PC_RESET;
            r_ir      <= 8'h00;
            r_wb      <= 8'h00;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_ir    <= imem_data;
                    r_pc    <= r_pc + 8'd1;
                    r_state <= DECODE;
                end
                DECODE: r_state <= (w_op == 4'hF) ? HALT : EXEC;
                EXEC: begin
                    r_state <= FETCH;
                    if (w_alu) begin
                        r_wb    <= alu_result;
                        r_state <= WB;
                    end
                    // LI: the immediate is the byte right after the opcode, so pc already points at it
                    if (w_op == 4'h9) begin
                        r_wb    <= imem_data;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= WB;
                    end
                    if (w_op == 4'h7) r_state <= MEM;
                    if ((w_op == 4'hA) || ((w_op == 4'hB) && (reg_data_1 == 8'h00))) r_pc <= reg_data_2;
                    if (w_op[3:2] == 2'b11) r_illegal <= 1'b1;
                end
                MEM: begin
                    r_wb    <= dmem_rdata;
                    r_state <= WB;
                end
                WB:      r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: bench with bank, ALU and memory models around the control FSM.
// Expected bank writes and stores are queued at setup and popped as the DUT strobes them.
module tb_unidade_controle_multiciclo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] imem_addr, imem_data, reg_data_1, reg_data_2, wb_data, alu_result;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0] read_register_1, read_register_2, write_register;
    logic       write_enable, dmem_we, halted, illegal;
    logic [2:0] alu_op;
    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    logic [7:0] bank [4];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [9:0]  exp_wr [$];
    logic [15:0] exp_st [$];
    int          wr_cyc [$];
    int          st_cyc [$];

    unidade_controle_multiciclo #(.PC_RESET(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .write_register(write_register),
        .write_enable(write_enable), .wb_data(wb_data), .alu_op(alu_op), .alu_result(alu_result),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign reg_data_1 = bank[read_register_1];
    assign reg_data_2 = bank[read_register_2];

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            3'd0: alu_result = reg_data_1 + reg_data_2;
            3'd1: alu_result = reg_data_1 - reg_data_2;
            3'd2: alu_result = reg_data_1 & reg_data_2;
            3'd3: alu_result = reg_data_1 | reg_data_2;
            3'd4: alu_result = ~reg_data_2;
            3'd5: alu_result = reg_data_2;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bank writes on the falling edge, like the real register bank
    always @(negedge clk) begin
        if (write_enable) begin
            check("wr_pending", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) check("wr_sel_data", {write_register, wb_data}, exp_wr.pop_front());
            wr_cyc.push_back(cyc);
            bank[write_register] = wb_data;
        end
        if (dmem_we) begin
            check("st_pending", 32'(exp_st.size() > 0), 1);
            if (exp_st.size() > 0) check("st_addr_data", {dmem_addr, dmem_wdata}, exp_st.pop_front());
            st_cyc.push_back(cyc);
            dmem[dmem_addr] = dmem_wdata;
        end
    end

    task automatic setup(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        bank[0] = r0;
        bank[1] = r1;
        bank[2] = r2;
        bank[3] = r3;
        wr_cyc.delete();
        st_cyc.delete();
    endtask

    task automatic go();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_wait", halted, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_pc", imem_addr, 8'h00);
        check("rst_strobes", {write_enable, dmem_we, halted, illegal}, 4'b0000);

        setup(8'h03, 8'h00, 8'h00, 8'h00);
        imem[0] = 8'h94; imem[1] = 8'h05; imem[2] = 8'h14; imem[3] = 8'hF0;
        exp_wr.push_back({2'd1, 8'h05});
        exp_wr.push_back({2'd1, 8'h08});
        go();
        wait_halt(60);
        check("add_r1", bank[1], 8'h08);
        check("add_nwr", wr_cyc.size(), 2);
        check("add_lat", wr_cyc.size() == 2 ? wr_cyc[1] - wr_cyc[0] : -1, 4);
        check("add_pc", imem_addr, 8'h04);

        setup(8'h00, 8'h00, 8'hA5, 8'h10);
        imem[0] = 8'h8B; imem[1] = 8'h73; imem[2] = 8'hF0;
        exp_st.push_back({8'h10, 8'hA5});
        exp_wr.push_back({2'd0, 8'hA5});
        go();
        wait_halt(60);
        check("ld_r0", bank[0], 8'hA5);
        check("st_mem", dmem[8'h10], 8'hA5);
        check("st_count", st_cyc.size(), 1);
        check("ld_lat", (st_cyc.size() == 1 && wr_cyc.size() == 1) ? wr_cyc[0] - st_cyc[0] : -1, 5);

        setup(8'h00, 8'h00, 8'h40, 8'h00);
        imem[0] = 8'hB6; imem[1] = 8'hF0; imem[8'h40] = 8'hF0;
        go();
        cycles(3);
        check("beqz_taken_pc", imem_addr, 8'h40);
        wait_halt(30);
        check("beqz_taken_halt_pc", imem_addr, 8'h41);

        setup(8'h00, 8'h01, 8'h40, 8'h00);
        imem[0] = 8'hB6; imem[1] = 8'hF0; imem[8'h40] = 8'hF0;
        go();
        cycles(3);
        check("beqz_fall_pc", imem_addr, 8'h01);
        wait_halt(30);
        check("beqz_fall_halt_pc", imem_addr, 8'h02);

        setup(8'h00, 8'h00, 8'hFF, 8'h00);
        imem[0] = 8'hA2; imem[1] = 8'hF0; imem[8'hFF] = 8'h94;
        exp_wr.push_back({2'd1, 8'hA2});
        go();
        cycles(6);
        check("li_wrap_pc", imem_addr, 8'h01);
        check("li_wrap_we", write_enable, 1);
        wait_halt(30);
        check("li_wrap_r1", bank[1], 8'hA2);
        check("li_wrap_halt_pc", imem_addr, 8'h02);

        setup(8'h00, 8'h00, 8'h00, 8'h00);
        imem[0] = 8'hC0; imem[1] = 8'hF0;
        go();
        cycles(3);
        check("ill_set", illegal, 1);
        wait_halt(30);
        check("halt_pc", imem_addr, 8'h02);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("halt_frozen", {imem_addr, write_enable, dmem_we, halted, illegal}, {8'h02, 4'b0011});
        end

        setup(8'h03, 8'h00, 8'h00, 8'h00);
        imem[0] = 8'hC0; imem[1] = 8'h94; imem[2] = 8'h05;
        go();
        cycles(6);
        check("arst_in_wb", {write_enable, illegal}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", write_enable, 0);
        check("arst_pc_ill", {imem_addr, illegal, halted}, {8'h00, 2'b00});
        @(negedge clk);
        #1;
        check("arst_no_write", bank[1], 8'h00);
        go();
        #1;
        check("arst_idle_pc", imem_addr, 8'h00);
        cycles(1);
        check("arst_refetch_pc", imem_addr, 8'h01);
        rst_n = 1'b0;
        #1;
        check("wr_left", exp_wr.size(), 0);
        check("st_left", exp_st.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Multicycle fetch/decode/control FSM for the 8-bit processor; sits directly upstream of the 4x8 general-purpose register bank.
- Fetches 8-bit instructions from instruction memory and decodes them.
- Drives the bank's read/write selects, write-enable and write data.
- Sequences ALU, data-memory and branch operations.
- Updates all state on the rising edge of clk, so bank controls are stable across the bank's falling-edge write.

Parameters:
PC_RESET, 8'h00, program counter value loaded on reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
imem_addr  out  8  instruction memory address; equals pc
imem_data  in  8  instruction memory read data, combinational read of imem_addr
read_register_1  out  2  bank read select 1
read_register_2  out  2  bank read select 2
reg_data_1  in  8  bank read data for read_register_1
reg_data_2  in  8  bank read data for read_register_2
write_register  out  2  bank write select
write_enable  out  1  bank write strobe
wb_data  out  8  bank write data
alu_op  out  3  ALU function code
alu_result  in  8  ALU result, combinational on reg_data_1 and reg_data_2
dmem_addr  out  8  data memory address; equals reg_data_2
dmem_wdata  out  8  data memory write data; equals reg_data_1
dmem_we  out  1  data memory write strobe
dmem_rdata  in  8  data memory read data, combinational
halted  out  1  high in HALT state
illegal  out  1  sticky flag; set by an undefined opcode

Behaviour:
- Instruction format: ir[7:4] opcode, ir[3:2] rd, ir[1:0] rs.
- Bank select wiring: read_register_1 = rd, read_register_2 = rs, write_register = rd.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT(rs), 6 MOV(rs): rd <- alu_result; alu_op = opcode-1 (0..5).
  - 7 LD: rd <- mem[rs].
  - 8 ST: mem[rs] <- rd.
  - 9 LI: rd <- following byte; two-byte instruction.
  - A JMP: pc <- reg[rs].
  - B BEQZ: if reg[rd]==0 then pc <- reg[rs].
  - F HALT.
  - C, D, E: executed as NOP and set illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: ir <= imem_data; pc <= pc+1 → DECODE.
- DECODE → HALT for opcode F; otherwise → EXEC.
- EXEC, per opcode:
  - ALU ops: wb_reg <= alu_result → WB.
  - LI: wb_reg <= imem_data; pc <= pc+1 → WB.
  - LD → MEM.
  - ST: dmem_we=1 this cycle → FETCH.
  - JMP: pc <= reg_data_2 → FETCH.
  - BEQZ: pc <= reg_data_2 if reg_data_1==0 → FETCH.
  - NOP/illegal → FETCH.
- MEM (LD only): wb_reg <= dmem_rdata → WB.
- WB: write_enable=1 and wb_data=wb_reg for the whole cycle → FETCH.
- write_enable is high only in WB. dmem_we is high only in EXEC for ST. Both are decoded combinationally from the state register; no glitch across the falling edge.
- Latency in cycles: NOP/JMP/BEQZ/ST/illegal 3; ALU ops 4; LI 4; LD 5.
- pc is 8 bits and wraps FF→00, including the LI immediate fetch at FF.
- HALT: absorbing; pc is frozen and all strobes are low. Only rst_n exits.
- illegal: stays set until reset.
- Reset (asynchronous, any state, mid-instruction): state=FETCH, pc=PC_RESET, ir=00, wb_reg=00, illegal=0.
- Outputs during reset: write_enable=0, dmem_we=0, halted=0; an in-progress write-back is aborted.

Test Plan:
- ALU write-back:
  - Setup: reset; imem[0]=0x9_4 (LI r1), imem[1]=0x05, imem[2]=0x1_4 → ADD r1,r0 with r0=0x03.
  - Required: write_enable pulses one cycle per write; bank r1=0x05, then 0x08.
  - Required: ADD completes exactly 4 cycles after its FETCH.
- Load/store:
  - Setup: ST r2→mem[r3], then LD r0←mem[r3], with r2=0xA5, r3=0x10.
  - Required: dmem_we high for one cycle with dmem_addr=0x10, dmem_wdata=0xA5; r0=0xA5.
  - Required: LD takes 5 cycles.
- Branch:
  - Setup: BEQZ with reg[rd]=0, reg[rs]=0x40.
  - Required: next imem_addr=0x40.
  - Setup: the same with reg[rd]=0x01.
  - Required: pc falls through to pc+1.
  - Setup: JMP to 0xFF followed by LI at 0xFF.
  - Required: immediate fetched from 0x00; pc=0x01 afterwards.
- Halt and illegal:
  - Setup: opcode 0xC0, then 0xF0.
  - Required: illegal=1 and stays set; halted=1; pc frozen for 20 cycles; no strobes.
- Asynchronous reset:
  - Stimulus: drop rst_n in the middle of WB, between clock edges.
  - Required: write_enable falls immediately with no bank write; pc=PC_RESET; illegal=0; fetch restarts at the first rising edge after release.
